packet_gen: RTL and testbench

Per-port packet generator driven by the cable-test controller's `pg_control_n` strobes. It emits a bounded stream of fixed-length, deterministically patterned packets on an AXI4-Stream master that feeds the Ethernet TX path. It reports busy, per-packet-sent and halted status back on `pg_status_n`. Two instances exist, one per Ethernet port.

---
 rtl/cabletest_pkg.sv | 41 ++++
 rtl/packet_pattern.sv | 21 ++
 rtl/packet_gen.sv | 142 ++++++++++++++
 tb/tb_packet_gen.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cabletest_pkg.sv
// Shared cable-test definitions: control/status bit positions and the
// deterministic lane pattern used by both the generator and the checker.
package cabletest_pkg;

  localparam int unsigned CTL_W      = 3;
  localparam int unsigned CTL_START  = 0;
  localparam int unsigned CTL_HALT   = 1;
  localparam int unsigned CTL_INJECT = 2;

  localparam int unsigned STA_W      = 3;
  localparam int unsigned STA_BUSY   = 0;
  localparam int unsigned STA_SENT   = 1;
  localparam int unsigned STA_HALTED = 2;

  localparam int unsigned PRS_W      = 3;
  localparam int unsigned PRS_LOCKED = 0;
  localparam int unsigned PRS_ERROR  = 1;
  localparam int unsigned PRS_DONE   = 2;

  localparam int unsigned LANE_W     = 32;
  localparam int unsigned SEQ_W      = 32;
  localparam int unsigned SEQ_LO_W   = 16;
  localparam int unsigned BEAT_W     = 8;
  localparam int unsigned LANE_ID_W  = 8;
  localparam int unsigned CNT_W      = 64;

  typedef enum logic [0:0] {
    PG_IDLE = 1'b0,
    PG_SEND = 1'b1
  } pg_state_e;

  // Only the low half of the sequence number appears on the wire.
  function automatic logic [LANE_W-1:0] pattern_word(
    input logic [SEQ_LO_W-1:0]  seq,
    input logic [BEAT_W-1:0]    beat,
    input logic [LANE_ID_W-1:0] lane
  );
    return {seq, beat, lane};
  endfunction

endpackage

// File: rtl/packet_pattern.sv
// Combinational full-width data word for a given (seq, beat); lane 0 in the LSBs.
module packet_pattern
  import cabletest_pkg::*;
#(
  parameter int unsigned DATA_WBITS = 512
) (
  input  logic [SEQ_LO_W-1:0]   seq,
  input  logic [BEAT_W-1:0]     beat,
  output logic [DATA_WBITS-1:0] word_c
);

  localparam int unsigned LANES = DATA_WBITS / LANE_W;

  always_comb begin
    word_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      word_c[i*LANE_W +: LANE_W] = pattern_word(seq, beat, LANE_ID_W'(i));
    end
  end

endmodule

// File: rtl/packet_gen.sv
// Per-port packet generator: bounded run of fixed-length patterned packets on
// an AXI4-Stream master, with halt-after-packet and single-bit error injection.
module packet_gen
  import cabletest_pkg::*;
#(
  parameter int unsigned DATA_WBITS = 512
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [CTL_W-1:0]      pg_control,
  input  logic [BEAT_W-1:0]     CYCLES_PER_PACKET,
  input  logic [CNT_W-1:0]      PACKET_COUNT,
  output logic [STA_W-1:0]      pg_status,
  output logic [DATA_WBITS-1:0] AXIS_TX_TDATA,
  output logic                  AXIS_TX_TLAST,
  output logic                  AXIS_TX_TVALID,
  input  logic                  AXIS_TX_TREADY
);

  pg_state_e          state;
  logic [BEAT_W-1:0]  cpp_q;
  logic [CNT_W-1:0]   remaining_q;
  logic [SEQ_W-1:0]   seq_q;
  logic [BEAT_W-1:0]  beat_q;
  logic               halt_pend_q;
  logic               inject_pend_q;
  logic               corrupt_q;

  logic               start;
  logic               halt;
  logic               inject;
  logic               xfer;
  logic               eop;
  logic               start_ok;
  logic               run_done;
  logic               load;
  logic               inj_block;
  logic [BEAT_W-1:0]  cpp_in;
  logic [BEAT_W-1:0]  cpp_sel;
  logic [SEQ_W-1:0]   nxt_seq;
  logic [BEAT_W-1:0]  nxt_beat;
  logic               nxt_last;
  logic [DATA_WBITS-1:0] word_c;

  assign start    = pg_control[CTL_START];
  assign halt     = pg_control[CTL_HALT];
  assign inject   = pg_control[CTL_INJECT];
  assign xfer     = AXIS_TX_TVALID & AXIS_TX_TREADY;
  assign eop      = xfer & AXIS_TX_TLAST;
  assign start_ok = (state == PG_IDLE) & start & (PACKET_COUNT != '0);
  assign cpp_in   = (CYCLES_PER_PACKET == '0) ? BEAT_W'(1) : CYCLES_PER_PACKET;
  assign cpp_sel  = start_ok ? cpp_in : cpp_q;
  // A halt arriving with a non-final TLAST stops the run right there.
  assign run_done = eop & ((remaining_q == CNT_W'(1)) | halt_pend_q | halt);
  assign load     = start_ok | (xfer & ~run_done);
  // An inject already pending, or riding on the beat in flight, absorbs new strobes.
  assign inj_block = inject_pend_q | (AXIS_TX_TVALID & corrupt_q);

  // Sequence/beat of the beat to be presented next cycle.
  always_comb begin
    nxt_seq  = seq_q;
    nxt_beat = beat_q;
    if (start_ok) begin
      nxt_seq  = '0;
      nxt_beat = '0;
    end else if (eop) begin
      nxt_seq  = seq_q + SEQ_W'(1);
      nxt_beat = '0;
    end else if (xfer) begin
      nxt_beat = beat_q + BEAT_W'(1);
    end
    nxt_last = (nxt_beat == (cpp_sel - BEAT_W'(1)));
  end

  packet_pattern #(
    .DATA_WBITS (DATA_WBITS)
  ) u_pattern (
    .seq    (nxt_seq[SEQ_LO_W-1:0]),
    .beat   (nxt_beat),
    .word_c (word_c)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state          <= PG_IDLE;
      cpp_q          <= '0;
      remaining_q    <= '0;
      seq_q          <= '0;
      beat_q         <= '0;
      halt_pend_q    <= 1'b0;
      inject_pend_q  <= 1'b0;
      corrupt_q      <= 1'b0;
      pg_status      <= '0;
      AXIS_TX_TDATA  <= '0;
      AXIS_TX_TLAST  <= 1'b0;
      AXIS_TX_TVALID <= 1'b0;
    end else begin
      pg_status[STA_SENT] <= eop;
      seq_q  <= nxt_seq;
      beat_q <= nxt_beat;

      case (state)
        PG_IDLE: begin
          if (start_ok) begin
            state                 <= PG_SEND;
            cpp_q                 <= cpp_in;
            remaining_q           <= PACKET_COUNT;
            halt_pend_q           <= 1'b0;
            pg_status[STA_HALTED] <= 1'b0;
            pg_status[STA_BUSY]   <= 1'b1;
            AXIS_TX_TVALID        <= 1'b1;
          end
        end
        PG_SEND: begin
          if (halt) halt_pend_q <= 1'b1;
          if (eop) remaining_q <= remaining_q - CNT_W'(1);
          if (run_done) begin
            state                 <= PG_IDLE;
            halt_pend_q           <= 1'b0;
            pg_status[STA_HALTED] <= (remaining_q != CNT_W'(1));
            pg_status[STA_BUSY]   <= 1'b0;
            AXIS_TX_TVALID        <= 1'b0;
            AXIS_TX_TLAST         <= 1'b0;
            corrupt_q             <= 1'b0;
          end
        end
        default: state <= PG_IDLE;
      endcase

      // A pending inject is consumed by the next beat loaded into the output register.
      if (load) begin
        AXIS_TX_TDATA <= word_c ^ DATA_WBITS'(inject_pend_q);
        AXIS_TX_TLAST <= nxt_last;
        corrupt_q     <= inject_pend_q;
        inject_pend_q <= inject & ~inj_block;
      end else begin
        inject_pend_q <= inject_pend_q | (inject & ~(AXIS_TX_TVALID & corrupt_q));
      end
    end
  end

endmodule

// File: tb/tb_packet_gen.sv
// Directed bench for packet_gen: table-driven backpressure vectors plus
// hand-written run, halt, inject, edge-case and reset sequences.
module tb_packet_gen;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         resetn;
  logic [2:0]   pg_control;
  logic [7:0]   cpp;
  logic [63:0]  pcount;
  logic [2:0]   pg_status;
  logic [W-1:0] tdata;
  logic         tlast;
  logic         tvalid;
  logic         tready;

  int checks = 0;
  int errors = 0;

  packet_gen #(.DATA_WBITS(W)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .pg_control        (pg_control),
    .CYCLES_PER_PACKET (cpp),
    .PACKET_COUNT      (pcount),
    .pg_status         (pg_status),
    .AXIS_TX_TDATA     (tdata),
    .AXIS_TX_TLAST     (tlast),
    .AXIS_TX_TVALID    (tvalid),
    .AXIS_TX_TREADY    (tready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       tready;
    logic       valid;
    logic       last;
    logic [7:0] seq;
    logic [7:0] beat;
    logic       sent;
    logic       busy;
  } vec_t;

  vec_t bp[9];

  function automatic logic [W-1:0] exp_word(input logic [31:0] seq, input logic [7:0] beat,
                                            input logic inj);
    logic [W-1:0] w;
    w = {seq[15:0], beat, 8'd1, seq[15:0], beat, 8'd0};
    w[0] = w[0] ^ inj;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic start_run(input logic [7:0] c, input logic [63:0] n);
    cpp        = c;
    pcount     = n;
    pg_control = 3'b001;
    step();
    pg_control = 3'b000;
  endtask

  task automatic pulse(input logic [2:0] bits);
    pg_control = bits;
    step();
    pg_control = 3'b000;
  endtask

  initial begin
    int k;
    int sent_cnt;
    int xfers;
    int bad;

    //            tready valid last seq   beat  sent busy
    bp[0] = '{1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1};
    bp[1] = '{1'b1, 1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1};
    bp[2] = '{1'b0, 1'b1, 1'b1, 8'd0, 8'd1, 1'b0, 1'b1};
    bp[3] = '{1'b1, 1'b1, 1'b1, 8'd0, 8'd1, 1'b0, 1'b1};
    bp[4] = '{1'b0, 1'b1, 1'b0, 8'd1, 8'd0, 1'b1, 1'b1};
    bp[5] = '{1'b1, 1'b1, 1'b0, 8'd1, 8'd0, 1'b0, 1'b1};
    bp[6] = '{1'b0, 1'b1, 1'b1, 8'd1, 8'd1, 1'b0, 1'b1};
    bp[7] = '{1'b1, 1'b1, 1'b1, 8'd1, 8'd1, 1'b0, 1'b1};
    bp[8] = '{1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b0};

    resetn = 1'b0; pg_control = '0; cpp = '0; pcount = '0; tready = 1'b1;
    step(); step();
    chk("reset_status", W'(pg_status), '0);
    chk("reset_tvalid", W'(tvalid), '0);
    chk("reset_tlast", W'(tlast), '0);
    chk("reset_tdata", tdata, '0);
    resetn = 1'b1;
    step();

    // Basic run: cpp=4, 3 packets, no backpressure.
    tready = 1'b1;
    start_run(8'd4, 64'd3);
    for (int i = 0; i < 12; i++) begin
      chk("basic_busy", W'(pg_status[0]), W'(1));
      chk("basic_valid", W'(tvalid), W'(1));
      chk("basic_last", W'(tlast), W'((i % 4) == 3));
      chk("basic_data", tdata, exp_word(32'(i / 4), 8'(i % 4), 1'b0));
      chk("basic_sent", W'(pg_status[1]), W'(((i % 4) == 0) && (i > 0)));
      if (i == 11) chk("basic_lane1", W'(tdata[63:32]), W'(32'h0002_0301));
      step();
    end
    chk("basic_end_busy", W'(pg_status[0]), '0);
    chk("basic_end_sent", W'(pg_status[1]), W'(1));
    chk("basic_end_valid", W'(tvalid), '0);
    chk("basic_end_halted", W'(pg_status[2]), '0);
    step();
    chk("basic_sent_pulse", W'(pg_status[1]), '0);

    // Backpressure: cpp=2, 2 packets, TREADY alternating.
    start_run(8'd2, 64'd2);
    xfers = 0;
    for (int i = 0; i < 9; i++) begin
      chk("bp_valid", W'(tvalid), W'(bp[i].valid));
      chk("bp_busy", W'(pg_status[0]), W'(bp[i].busy));
      chk("bp_sent", W'(pg_status[1]), W'(bp[i].sent));
      if (bp[i].valid) begin
        chk("bp_last", W'(tlast), W'(bp[i].last));
        chk("bp_data", tdata, exp_word(32'(bp[i].seq), bp[i].beat, 1'b0));
      end
      tready = bp[i].tready;
      if (tvalid && tready) xfers++;
      step();
    end
    chk("bp_xfers", W'(xfers), W'(4));
    tready = 1'b1;

    // Halt at beat 3 of packet 5: packet 5 completes, then stop.
    start_run(8'd8, 64'd100);
    k = 0; sent_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (!pg_status[0]) break;
      if (pg_status[1]) sent_cnt++;
      if (k == 43) chk("halt_point_data", tdata, exp_word(32'd5, 8'd3, 1'b0));
      pg_control = (k == 43) ? 3'b010 : 3'b000;
      if (tvalid && tready) k++;
      step();
    end
    pg_control = 3'b000;
    if (pg_status[1]) sent_cnt++;
    chk("halt_beats", W'(k), W'(48));
    chk("halt_sent_count", W'(sent_cnt), W'(6));
    chk("halt_busy", W'(pg_status[0]), '0);
    chk("halt_halted", W'(pg_status[2]), W'(1));
    start_run(8'd3, 64'd0);
    chk("zero_count_busy", W'(pg_status[0]), '0);
    chk("zero_count_valid", W'(tvalid), '0);
    chk("zero_count_halted_kept", W'(pg_status[2]), W'(1));
    start_run(8'd1, 64'd1);
    chk("restart_halted_clr", W'(pg_status[2]), '0);
    chk("restart_busy", W'(pg_status[0]), W'(1));
    chk("restart_last", W'(tlast), W'(1));
    step();
    chk("restart_done_busy", W'(pg_status[0]), '0);
    chk("restart_done_sent", W'(pg_status[1]), W'(1));

    // Inject while idle corrupts only beat 0 of the next run.
    pulse(3'b100);
    start_run(8'd4, 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("inj_idle_data", tdata, exp_word(32'd0, 8'(i), i == 0));
      step();
    end
    chk("inj_idle_busy", W'(pg_status[0]), '0);

    // Two injects during a stall produce a single corrupted beat.
    tready = 1'b0;
    start_run(8'd4, 64'd1);
    chk("inj_stall_d0", tdata, exp_word(32'd0, 8'd0, 1'b0));
    pulse(3'b100);
    chk("inj_stall_d1", tdata, exp_word(32'd0, 8'd0, 1'b0));
    pulse(3'b100);
    chk("inj_stall_d2", tdata, exp_word(32'd0, 8'd0, 1'b0));
    tready = 1'b1;
    k = 0; bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!tvalid) break;
      if (tdata[0]) bad++;
      chk("inj_stall_data", tdata, exp_word(32'd0, 8'(k), k == 1));
      k++;
      step();
    end
    chk("inj_stall_beats", W'(k), W'(4));
    chk("inj_stall_corrupt", W'(bad), W'(1));

    // cpp=0 behaves as single-beat packets.
    start_run(8'd0, 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk("cpp0_valid", W'(tvalid), W'(1));
      chk("cpp0_last", W'(tlast), W'(1));
      chk("cpp0_data", tdata, exp_word(32'(i), 8'd0, 1'b0));
      step();
    end
    chk("cpp0_busy", W'(pg_status[0]), '0);

    // START while busy is ignored.
    start_run(8'd2, 64'd1);
    cpp = 8'd7; pcount = 64'd9;
    pulse(3'b001);
    chk("busy_start_data", tdata, exp_word(32'd0, 8'd1, 1'b0));
    chk("busy_start_last", W'(tlast), W'(1));
    step();
    chk("busy_start_done", W'(pg_status[0]), '0);

    // HALT coinciding with the final TLAST is a normal completion.
    start_run(8'd2, 64'd2);
    step(); step(); step();
    chk("final_halt_last", W'(tlast), W'(1));
    pulse(3'b010);
    chk("final_halt_busy", W'(pg_status[0]), '0);
    chk("final_halt_halted", W'(pg_status[2]), '0);
    chk("final_halt_sent", W'(pg_status[1]), W'(1));

    // Reset in the middle of a packet abandons it.
    start_run(8'd4, 64'd2);
    step(); step();
    chk("rst_mid_data", tdata, exp_word(32'd0, 8'd2, 1'b0));
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    chk("rst_mid_valid", W'(tvalid), '0);
    chk("rst_mid_status", W'(pg_status), '0);
    chk("rst_mid_tdata", tdata, '0);
    step(); step(); step();
    chk("rst_mid_no_resume", W'(tvalid), '0);
    chk("rst_mid_idle", W'(pg_status[0]), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
